// File: rtl/ysyx_220053_pkg.sv
// rtl/ysyx_220053_pkg.sv - shared constants and types for the fetch unit
package ysyx_220053_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ysyx_220053_fetch_fifo.sv
// rtl/ysyx_220053_fetch_fifo.sv - small instruction buffer with synchronous flush
module ysyx_220053_fetch_fifo
  import ysyx_220053_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             push,
  input  fetch_entry_t                     push_data,
  input  logic                             pop,
  output fetch_entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flush wins over everything, so a same-cycle pop or push is simply absorbed.
  assign do_push = push & ~flush;
  assign do_pop  = pop & (cnt != '0) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/ysyx_220053_fetch.sv
// rtl/ysyx_220053_fetch.sv - instruction fetch: PC, credit-limited requests, redirect flush
module ysyx_220053_fetch
  import ysyx_220053_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [63:0]   pc;
  logic [63:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [CW:0]   inflight;
  logic [63:0]   target;
  logic          req_fire;
  logic          rsp_fire;
  logic          keep;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  assign inflight       = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = rst_n & ~redirect_valid & (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  // A response with nothing outstanding is a leftover from before reset.
  assign rsp_fire       = imem_rsp_valid & (outstanding != '0);
  assign keep           = rsp_fire & (drop_cnt == '0) & ~redirect_valid;
  assign target         = {redirect_pc[63:2], 2'b00};
  assign push_data      = '{pc: resp_pc, instr: imem_rsp_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (redirect_valid) begin
        pc       <= target;
        resp_pc  <= target;
        // Everything still in flight after this edge belongs to the old path.
        drop_cnt <= outstanding - CW'(rsp_fire);
      end else begin
        if (req_fire) pc <= pc + 64'd4;
        if (keep) resp_pc <= resp_pc + 64'd4;
        if (rsp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  ysyx_220053_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (keep),
    .push_data (push_data),
    .pop       (instr_valid & instr_ready),
    .head      (head),
    .count     (count)
  );

  assign instr_valid = (count != '0);
  assign instr_o     = head.instr;
  assign pc_o        = head.pc;

  assert property (@(posedge clk) disable iff (!rst_n) drop_cnt <= outstanding);
  assert property (@(posedge clk) disable iff (!rst_n) inflight <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_ysyx_220053_fetch.sv
// tb/tb_ysyx_220053_fetch.sv - directed bench for the fetch unit
module tb_ysyx_220053_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int          pass_cnt = 0;
  int          total    = 0;
  int          req_count = 0;
  int          inject_req = 0;
  int          inject_done = 0;
  bit          rsp_hold = 0;
  logic [63:0] addr_q [$];

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  ysyx_220053_fetch #(.DEPTH(2), .RESET_PC(64'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5a5a_0013;
  endfunction

  // Memory model: one-cycle latency, in order, optional hold and spurious response.
  initial begin
    logic [63:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        addr_q.push_back(imem_req_addr);
        req_count++;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        addr_q.delete();
        imem_rsp_valid = 1'b0;
      end else if (inject_req != inject_done) begin
        inject_done    = inject_req;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hdead_beef;
      end else if (!rsp_hold && addr_q.size() > 0) begin
        a              = addr_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(a);
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  task automatic drain();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b1;
    rsp_hold       = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b expected 0", instr_valid); else pass_cnt++;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1) $display("FAIL rst_first_req_valid: got %b expected 1", imem_req_valid); else pass_cnt++;
    total++; if (imem_req_addr !== RST_PC) $display("FAIL rst_first_addr: got %h expected %h", imem_req_addr, RST_PC); else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [63:0] exp;
    int got;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    exp = RST_PC;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        total++; if (pc_o !== exp) $display("FAIL stream_pc: got %h expected %h", pc_o, exp); else pass_cnt++;
        total++; if (instr_o !== instr_of(exp)) $display("FAIL stream_instr: got %h expected %h", instr_o, instr_of(exp)); else pass_cnt++;
        exp = exp + 64'd4;
        got++;
      end
    end
    total++; if (got != 6) $display("FAIL stream_count: got %0d expected 6", got); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) $display("FAIL mid_rst_instr_valid: got %b expected 0", instr_valid); else pass_cnt++;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL mid_rst_req_valid: got %b expected 0", imem_req_valid); else pass_cnt++;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (imem_req_addr !== RST_PC) $display("FAIL mid_rst_addr: got %h expected %h", imem_req_addr, RST_PC); else pass_cnt++;
    total++; if (imem_req_valid !== 1'b1) $display("FAIL mid_rst_req_valid_after: got %b expected 1", imem_req_valid); else pass_cnt++;
  endtask

  task automatic test_mem_stall();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (imem_req_addr !== RST_PC) $display("FAIL stall_addr: got %h expected %h", imem_req_addr, RST_PC); else pass_cnt++;
      total++; if (imem_req_valid !== 1'b1) $display("FAIL stall_valid: got %b expected 1", imem_req_valid); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp;
    int base;
    int got;
    base = req_count;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (req_count - base != 2) $display("FAIL bp_req_count: got %0d expected 2", req_count - base); else pass_cnt++;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); else pass_cnt++;
    total++; if (instr_valid !== 1'b1) $display("FAIL bp_instr_valid: got %b expected 1", instr_valid); else pass_cnt++;
    instr_ready = 1'b1;
    exp = RST_PC;
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (instr_valid) begin
        total++; if (pc_o !== exp) $display("FAIL bp_pc: got %h expected %h", pc_o, exp); else pass_cnt++;
        total++; if (instr_o !== instr_of(exp)) $display("FAIL bp_instr: got %h expected %h", instr_o, instr_of(exp)); else pass_cnt++;
        exp = exp + 64'd4;
        got++;
      end
    end
    total++; if (got != 5) $display("FAIL bp_count: got %0d expected 5", got); else pass_cnt++;
    drain();
  endtask

  task automatic test_redirect_inflight();
    logic [63:0] exp;
    int got;
    rsp_hold = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) $display("FAIL redir_credit: got %b expected 0", imem_req_valid); else pass_cnt++;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL redir_noreq: got %b expected 0", imem_req_valid); else pass_cnt++;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) $display("FAIL redir_empty: got %b expected 0", instr_valid); else pass_cnt++;
    total++; if (imem_req_addr !== 64'h8000_0100) $display("FAIL redir_addr: got %h expected 0000000080000100", imem_req_addr); else pass_cnt++;
    rsp_hold = 1'b0;
    exp = 64'h8000_0100;
    got = 0;
    for (int c = 0; c < 30 && got < 3; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        total++; if (pc_o !== exp) $display("FAIL redir_pc: got %h expected %h", pc_o, exp); else pass_cnt++;
        total++; if (instr_o !== instr_of(exp)) $display("FAIL redir_instr: got %h expected %h", instr_o, instr_of(exp)); else pass_cnt++;
        exp = exp + 64'd4;
        got++;
      end
    end
    total++; if (got != 3) $display("FAIL redir_count: got %0d expected 3", got); else pass_cnt++;
    drain();
  endtask

  task automatic test_redirect_same_cycle();
    int got;
    @(negedge clk);
    imem_req_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL same_noreq: got %b expected 0", imem_req_valid); else pass_cnt++;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    total++; if (imem_req_addr !== 64'h8000_0100) $display("FAIL same_addr: got %h expected 0000000080000100", imem_req_addr); else pass_cnt++;
    total++; if (imem_req_valid !== 1'b1) $display("FAIL same_req_valid: got %b expected 1", imem_req_valid); else pass_cnt++;
    got = 0;
    for (int c = 0; c < 20 && got < 1; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        total++; if (pc_o !== 64'h8000_0100) $display("FAIL same_pc: got %h expected 0000000080000100", pc_o); else pass_cnt++;
        total++; if (instr_o !== instr_of(64'h8000_0100)) $display("FAIL same_instr: got %h expected %h", instr_o, instr_of(64'h8000_0100)); else pass_cnt++;
        got++;
      end
    end
    total++; if (got != 1) $display("FAIL same_timeout: got %0d expected 1", got); else pass_cnt++;
    drain();
  endtask

  task automatic test_spurious_rsp();
    inject_req++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (instr_valid !== 1'b0) $display("FAIL spurious_instr_valid: got %b expected 0", instr_valid); else pass_cnt++;
    end
    total++; if (imem_req_valid !== 1'b1) $display("FAIL spurious_req_valid: got %b expected 1", imem_req_valid); else pass_cnt++;
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_streaming();
    test_reset_mid();
    test_mem_stall();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_spurious_rsp();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
